// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code width and the capture FSM state type.
// Also carries a small helper used to size counters at elaboration.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } capture_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_counter.sv
// Stability counter shared by the press and release intervals; done flags the
// terminal count of whichever interval sel_rel selects. clr has priority over inc.
module debounce_counter #(
    parameter int W      = 2,
    parameter int DEB_TC = 3,
    parameter int REL_TC = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic inc,
    input  logic sel_rel,
    output logic done
);

    localparam logic [W-1:0] DEB_T = W'(DEB_TC);
    localparam logic [W-1:0] REL_T = W'(REL_TC);

    logic [W-1:0] cnt_q, cnt_d;

    // clr together with inc restarts the count at 1 (state entry counts the entry cycle).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == (sel_rel ? REL_T : DEB_T));

endmodule

// File: rtl/key_capture.sv
// Debounced key capture: accepts one digit per stable press, re-arms after a
// stable release, and keeps a newest/previous digit history for the display.
module key_capture
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RELEASE_CYCLES  = 50000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_code,
    output logic [KEY_W-1:0] digit_new,
    output logic [KEY_W-1:0] digit_old,
    output logic             key_strobe,
    output logic             busy
);

    localparam int CNT_W = $clog2(max2(DEBOUNCE_CYCLES, RELEASE_CYCLES));

    if (DEBOUNCE_CYCLES < 2 || RELEASE_CYCLES < 2) begin : g_param_chk
        $error("key_capture: DEBOUNCE_CYCLES and RELEASE_CYCLES must both be >= 2");
    end

    capture_state_t   state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] new_q, new_d;
    logic [KEY_W-1:0] old_q, old_d;
    logic             strobe_q, strobe_d;
    logic             cnt_clr, cnt_inc, cnt_sel_rel, cnt_done;

    debounce_counter #(
        .W      (CNT_W),
        .DEB_TC (DEBOUNCE_CYCLES - 1),
        .REL_TC (RELEASE_CYCLES - 1)
    ) u_cnt (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .sel_rel (cnt_sel_rel),
        .done    (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        new_d       = new_q;
        old_d       = old_q;
        strobe_d    = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        cnt_sel_rel = (state_q == RELEASE);
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    cand_d  = key_code;
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_valid || key_code != cand_q) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (cnt_done) begin
                    old_d    = new_q;
                    new_d    = cand_q;
                    strobe_d = 1'b1;
                    state_d  = HELD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HELD: begin
                // Any key activity while held is ignored until a release is seen.
                if (!key_valid) begin
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (key_valid) begin
                    cnt_clr = 1'b1;
                    state_d = HELD;
                end else if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            new_q    <= '0;
            old_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            new_q    <= new_d;
            old_q    <= old_d;
            strobe_q <= strobe_d;
        end
    end

    assign digit_new  = new_q;
    assign digit_old  = old_q;
    assign key_strobe = strobe_q;
    assign busy       = (state_q != IDLE);

endmodule
